fpu_cmd_issuer: RTL and testbench

Front-end sequencer that drives the FPU core from the host side of the FPU instruction interface. It accepts `fpu_instruction_t` words from a host over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time to the FPU core with a start/done handshake and returns each result plus `flags_t` to the host over a second valid/ready channel. It also keeps sticky exception flags and detects a hung core.

---
 rtl/definitions.sv | 68 ++++++
 rtl/fpu_instr_fifo.sv | 42 ++++
 rtl/fpu_cmd_issuer.sv | 145 ++++++++++++++
 tb/tb_fpu_cmd_issuer.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared types for the host-side FPU instruction path: operations, float/flag
// layouts, the instruction word and the issuer's response record.
package definitions;

  typedef enum logic [2:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MUL  = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_SQRT = 3'd4
  } fpu_op_t;

  typedef enum logic [1:0] {
    RND_NEAREST = 2'd0,
    RND_ZERO    = 2'd1,
    RND_UP      = 2'd2,
    RND_DOWN    = 2'd3
  } round_mode_t;

  typedef struct packed {
    logic       sign;
    logic [7:0] exponent;
    logic [22:0] mantissa;
  } float_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic qnan;
    logic snan;
    logic divbyzero;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  typedef struct packed {
    fpu_op_t     fpu_op;
    round_mode_t rnd_mode;
    float_t      operand;
  } fpu_instruction_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } issuer_state_t;

  typedef struct packed {
    fpu_op_t op;
    float_t  result;
    flags_t  flags;
  } fpu_rsp_t;

  localparam float_t QNAN = 32'h7FC0_0000;

  // Response used whenever the core cannot supply a real result.
  function automatic fpu_rsp_t qnan_rsp(input fpu_op_t op);
    fpu_rsp_t r;
    r = '0;
    r.op = op;
    r.result = QNAN;
    r.flags.qnan = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fpu_instr_fifo.sv
// Synchronous FIFO of FPU instruction words; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module fpu_instr_fifo
  import definitions::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  fpu_instruction_t wdata,
  output fpu_instruction_t rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  fpu_instruction_t mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Buffers host FPU instructions, issues them one at a time to the core and
// returns result/flags to the host; tracks sticky flags and core hangs.
module fpu_cmd_issuer
  import definitions::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [36:0] in_instr,
  output logic        fpu_start,
  output logic [36:0] fpu_instr,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  input  logic [7:0]  fpu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [7:0]  rsp_flags,
  output logic [2:0]  rsp_op,
  output logic [7:0]  sticky_flags,
  input  logic        sticky_clr,
  output logic        timeout_err,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  // Last WAIT count at which a missing done forces the qNaN response.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  issuer_state_t    state;
  issuer_state_t    next_state;
  fpu_instruction_t head;
  fpu_instruction_t instr_q;
  fpu_rsp_t         rsp_q;
  flags_t           sticky_q;
  logic [CW-1:0]    cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             op_valid;
  logic             load_core;
  logic             load_qnan;
  logic             timed_out;
  logic             rsp_fire;

  fpu_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && !fifo_full),
    .pop   (pop),
    .wdata (in_instr),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign op_valid = (head.fpu_op <= FPU_SQRT);
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    fpu_start  = 1'b0;
    load_core  = 1'b0;
    load_qnan  = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) next_state = ISSUE;
      end
      ISSUE: begin
        pop = 1'b1;
        if (op_valid) begin
          fpu_start  = 1'b1;
          next_state = WAIT;
        end else begin
          load_qnan  = 1'b1;
          next_state = RESP;
        end
      end
      WAIT: begin
        if (fpu_done) begin
          load_core  = 1'b1;
          next_state = RESP;
        end else if (cnt == CNT_LAST) begin
          load_qnan  = 1'b1;
          timed_out  = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) next_state = fifo_empty ? IDLE : ISSUE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Instruction hold register, timeout counter, response and sticky state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q     <= '0;
      rsp_q       <= '0;
      cnt         <= '0;
      sticky_q    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        instr_q <= head;
        cnt     <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (load_core) begin
        rsp_q.op     <= instr_q.fpu_op;
        rsp_q.result <= fpu_result;
        rsp_q.flags  <= fpu_flags;
      end else if (load_qnan) begin
        rsp_q <= qnan_rsp((state == ISSUE) ? head.fpu_op : instr_q.fpu_op);
      end
      if (timed_out) timeout_err <= 1'b1;
      if (sticky_clr)    sticky_q <= rsp_fire ? rsp_q.flags : '0;
      else if (rsp_fire) sticky_q <= sticky_q | rsp_q.flags;
    end
  end

  // During ISSUE the head is shown directly so the core sees it with fpu_start.
  assign fpu_instr    = (state == ISSUE) ? head : instr_q;
  assign in_ready     = !fifo_full;
  assign rsp_valid    = (state == RESP);
  assign rsp_result   = rsp_q.result;
  assign rsp_flags    = rsp_q.flags;
  assign rsp_op       = rsp_q.op;
  assign sticky_flags = sticky_q;
  assign busy         = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Scoreboard bench for fpu_cmd_issuer with a simple latency-programmable core model.
module tb_fpu_cmd_issuer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam logic [92:0] RESET_OUTS = {1'b1, 92'b0};

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] result;
    logic [7:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [36:0] in_instr = '0;
  logic        fpu_start;
  logic [36:0] fpu_instr;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [7:0]  fpu_flags;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [7:0]  rsp_flags;
  logic [2:0]  rsp_op;
  logic [7:0]  sticky_flags;
  logic        sticky_clr = 1'b0;
  logic        timeout_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int start_count = 0;
  int rsp_seen = 0;
  int core_latency = 1;
  int core_cnt = -1;
  bit core_hold = 1'b0;
  bit late_pulse = 1'b0;
  logic [7:0]  core_flags = '0;
  logic [36:0] core_instr = '0;
  int   start_cycles[$];
  exp_t sb[$];

  fpu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .fpu_start    (fpu_start),
    .fpu_instr    (fpu_instr),
    .fpu_done     (fpu_done),
    .fpu_result   (fpu_result),
    .fpu_flags    (fpu_flags),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_op       (rsp_op),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [92:0] outs();
    return {in_ready, fpu_start, fpu_instr, rsp_valid, rsp_result, rsp_flags,
            rsp_op, sticky_flags, timeout_err, busy};
  endfunction

  // Core model: answers each start after core_latency cycles with the operand as result.
  initial begin
    fpu_done = 1'b0;
    fpu_result = '0;
    fpu_flags = '0;
    forever begin
      @(negedge clk);
      fpu_done = 1'b0;
      if (!rst_n) begin
        core_cnt = -1;
      end else if (late_pulse) begin
        fpu_done = 1'b1;
        fpu_result = 32'hDEAD_BEEF;
        fpu_flags = 8'hFF;
        late_pulse = 1'b0;
        core_cnt = -1;
      end else if (core_cnt > 0) begin
        core_cnt--;
      end else if (core_cnt == 0 && !core_hold) begin
        fpu_done = 1'b1;
        fpu_result = core_instr[31:0];
        fpu_flags = core_flags;
        core_cnt = -1;
      end
      if (rst_n && fpu_start) begin
        core_instr = fpu_instr;
        core_cnt = core_latency - 1;
        start_count++;
        start_cycles.push_back(cycle);
      end
    end
  end

  // Response monitor: pops the scoreboard on every handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL rsp_unexpected: got op=%0d result=%h flags=%h, required no response",
                   rsp_op, rsp_result, rsp_flags);
        end else begin
          e = sb.pop_front();
          rsp_seen++;
          if ({rsp_op, rsp_result, rsp_flags} !== {e.op, e.result, e.flags}) begin
            errors++;
            $display("[TB] FAIL rsp_data: got op=%0d result=%h flags=%h, required op=%0d result=%h flags=%h",
                     rsp_op, rsp_result, rsp_flags, e.op, e.result, e.flags);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_instr(input logic [2:0] op, input logic [31:0] operand,
                            input bit expect_timeout, output bit ok);
    exp_t e;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = {op, 2'b01, operand};
    for (int n = 0; n < 200; n++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (ok) begin
      if (op > 3'd4 || expect_timeout) e = '{op: op, result: 32'h7FC0_0000, flags: 8'h20};
      else                             e = '{op: op, result: operand, flags: core_flags};
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== RESET_OUTS) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, required %h", outs(), RESET_OUTS);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== RESET_OUTS) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %h, required %h", outs(), RESET_OUTS);
    end
  endtask

  task automatic test_single_add();
    bit ok;
    core_latency = 3;
    core_flags = 8'h00;
    rsp_ready = 1'b1;
    push_instr(3'd0, 32'h4040_0000, 1'b0, ok);
    checks++;
    if ({ok, fpu_start, busy} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL add_accept: got ok/start/busy=%b, required 101", {ok, fpu_start, busy});
    end
    @(negedge clk);
    checks++;
    if ({fpu_start, fpu_instr} !== {1'b1, 3'd0, 2'b01, 32'h4040_0000}) begin
      errors++;
      $display("[TB] FAIL add_issue: got start=%b instr=%h, required start=1 instr=%h",
               fpu_start, fpu_instr, {3'd0, 2'b01, 32'h4040_0000});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_rsp_early: got rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_rsp_latency: got rsp_valid=%b, required 1", rsp_valid);
    end
    wait_drain(ok);
    checks++;
    if ({ok, sticky_flags} !== {1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL add_done: got drained=%b sticky=%h, required drained=1 sticky=00", ok, sticky_flags);
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit all_ok = 1'b1;
    bit ready_after4 = 1'b0;
    bit ready_seen = 1'b0;
    int s0 = start_count;
    int r0 = rsp_seen;
    core_latency = 1;
    core_hold = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_instr(3'(i), 32'h3F00_0000 + 32'(i), 1'b0, ok);
      all_ok &= ok;
      if (i == 3) ready_after4 = in_ready;
    end
    for (int i = 0; i < 5; i++) begin
      ready_seen |= in_ready;
      @(negedge clk);
    end
    checks++;
    if ({all_ok, ready_after4, ready_seen, start_count - s0} !== {3'b110, 32'd1}) begin
      errors++;
      $display("[TB] FAIL fifo_full: got ok=%b ready_after4=%b ready_when_full=%b starts=%0d, required 1 1 0 1",
               all_ok, ready_after4, ready_seen, start_count - s0);
    end
    core_hold = 1'b0;
    wait_drain(ok);
    checks++;
    if ({ok, rsp_seen - r0} !== {1'b1, 32'd5}) begin
      errors++;
      $display("[TB] FAIL fifo_drain: got drained=%b responses=%0d, required 1 and 5", ok, rsp_seen - r0);
    end
  endtask

  task automatic test_hold_response();
    bit ok;
    bit got = 1'b0;
    int s0 = start_count;
    core_latency = 1;
    core_flags = 8'h00;
    rsp_ready = 1'b0;
    push_instr(3'd2, 32'h3F80_0000, 1'b0, ok);
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    push_instr(3'd1, 32'h4000_0000, 1'b0, ok);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_op, rsp_result, rsp_flags} !== {1'b1, 3'd2, 32'h3F80_0000, 8'h00}) begin
        errors++;
        $display("[TB] FAIL hold_stable[%0d]: got valid=%b op=%0d result=%h flags=%h, required 1 2 3f800000 00",
                 i, rsp_valid, rsp_op, rsp_result, rsp_flags);
      end
      @(negedge clk);
    end
    checks++;
    if ({got, start_count - s0} !== {1'b1, 32'd1}) begin
      errors++;
      $display("[TB] FAIL hold_no_start: got rsp_seen=%b starts=%0d, required 1 and 1", got, start_count - s0);
    end
    rsp_ready = 1'b1;
    wait_drain(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_drain: got drained=%b, required 1", ok);
    end
  endtask

  task automatic test_invalid_op();
    bit ok;
    int s0 = start_count;
    rsp_ready = 1'b1;
    push_instr(3'b110, 32'h1234_5678, 1'b0, ok);
    wait_drain(ok);
    checks++;
    if ({ok, start_count - s0} !== {1'b1, 32'd0}) begin
      errors++;
      $display("[TB] FAIL invalid_op: got drained=%b starts=%0d, required 1 and 0", ok, start_count - s0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit spurious = 1'b0;
    int c = 0;
    core_hold = 1'b1;
    rsp_ready = 1'b1;
    push_instr(3'd3, 32'h4080_0000, 1'b1, ok);
    for (int n = 0; n < 20 && !fpu_start; n++) @(negedge clk);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      c++;
      if (rsp_valid) break;
    end
    checks++;
    if ({c, timeout_err} !== {32'(TIMEOUT), 1'b1}) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got cycles=%0d err=%b, required %0d and 1", c, timeout_err, TIMEOUT);
    end
    wait_drain(ok);
    late_pulse = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      spurious |= rsp_valid | busy;
    end
    core_hold = 1'b0;
    checks++;
    if ({ok, spurious} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL timeout_late_done: got drained=%b spurious=%b, required 1 0", ok, spurious);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int gap1;
    int gap2;
    core_latency = 1;
    rsp_ready = 1'b1;
    start_cycles.delete();
    for (int i = 0; i < 3; i++) push_instr(3'd0, 32'h4100_0000 + 32'(i), 1'b0, ok);
    wait_drain(ok);
    gap1 = (start_cycles.size() == 3) ? start_cycles[1] - start_cycles[0] : -1;
    gap2 = (start_cycles.size() == 3) ? start_cycles[2] - start_cycles[1] : -1;
    checks++;
    if ({ok, gap1, gap2} !== {1'b1, 32'd3, 32'd3}) begin
      errors++;
      $display("[TB] FAIL back_to_back: got drained=%b gaps=%0d,%0d, required 1 and 3,3", ok, gap1, gap2);
    end
  endtask

  task automatic test_sticky();
    bit ok;
    rsp_ready = 1'b1;
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    checks++;
    if (sticky_flags !== 8'h00) begin
      errors++;
      $display("[TB] FAIL sticky_clear: got %h, required 00", sticky_flags);
    end
    core_flags = 8'h04;
    push_instr(3'd2, 32'h7F7F_FFFF, 1'b0, ok);
    wait_drain(ok);
    checks++;
    if (sticky_flags !== 8'h04) begin
      errors++;
      $display("[TB] FAIL sticky_overflow: got %h, required 04", sticky_flags);
    end
    core_flags = 8'h08;
    push_instr(3'd3, 32'h3F80_0000, 1'b0, ok);
    wait_drain(ok);
    checks++;
    if (sticky_flags !== 8'h0C) begin
      errors++;
      $display("[TB] FAIL sticky_divbyzero: got %h, required 0c", sticky_flags);
    end
    core_flags = 8'h01;
    rsp_ready = 1'b0;
    push_instr(3'd0, 32'h3EAA_AAAB, 1'b0, ok);
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    rsp_ready = 1'b1;
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    checks++;
    if (sticky_flags !== 8'h01) begin
      errors++;
      $display("[TB] FAIL sticky_clr_with_rsp: got %h, required 01", sticky_flags);
    end
    wait_drain(ok);
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    bit activity = 1'b0;
    int s0;
    core_hold = 1'b1;
    core_latency = 1;
    rsp_ready = 1'b1;
    push_instr(3'd1, 32'h4000_0000, 1'b0, ok);
    push_instr(3'd4, 32'h4080_0000, 1'b0, ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    core_hold = 1'b0;
    checks++;
    if (outs() !== RESET_OUTS) begin
      errors++;
      $display("[TB] FAIL reset_mid_wait: got %h, required %h", outs(), RESET_OUTS);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = start_count;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      activity |= rsp_valid | busy | fpu_start;
    end
    checks++;
    if ({activity, start_count - s0} !== {1'b0, 32'd0}) begin
      errors++;
      $display("[TB] FAIL reset_flush: got activity=%b starts=%0d, required 0 and 0", activity, start_count - s0);
    end
  endtask

  initial begin
    $display("[TB] starting fpu_cmd_issuer bench");
    test_reset();
    test_single_add();
    test_fifo_full();
    test_hold_response();
    test_invalid_op();
    test_timeout();
    test_back_to_back();
    test_sticky();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
